pipe_hazard_ctrl: RTL and testbench

- Consumer side of the load-use hazard interface. Takes the hazard unit's stall request, EX branch redirect, and instruction/data memory ready handshakes.
- Drives per-stage enable and flush controls for the 5-stage core (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Keeps a small state machine for multi-cycle memory waits, post-flush request suppression and a stall watchdog.
- Keeps saturating bubble/flush performance counters.

---
 rtl/core_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core pipeline control slice.
package core_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALL   = 2'd1,
      MEMWAIT = 2'd2,
      FLUSH   = 2'd3
   } hz_state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stage enable/flush control: memory freeze, branch flush, load-use
// bubble, fetch bubble, plus a stall watchdog and saturating perf counters.
module pipe_hazard_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_req,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             err_stall
);

   localparam int unsigned RUN_W = 8;

   hz_state_t        state, state_nxt;
   logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
   logic             err_nxt;
   logic             stall_eff;
   logic             bubble_inc;
   logic             flush_inc;

   // State, stall-run counter and sticky watchdog flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         run_cnt   <= '0;
         err_stall <= 1'b0;
      end else begin
         state     <= state_nxt;
         run_cnt   <= run_cnt_nxt;
         err_stall <= err_nxt;
      end
   end

   // Priority decode; during reset inputs are masked so outputs read as RUN
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      state_nxt   = RUN;
      run_cnt_nxt = '0;
      err_nxt     = err_stall;
      bubble_inc  = 1'b0;
      flush_inc   = 1'b0;
      stall_eff   = stall_req && (state != FLUSH);

      if (!rst_n) begin
         state_nxt = RUN;
      end else if (dmem_req && !dmem_ready) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         state_nxt   = MEMWAIT;
         run_cnt_nxt = run_cnt;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_nxt  = FLUSH;
         flush_inc  = 1'b1;
      end else if (stall_eff) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
         state_nxt  = STALL;
         bubble_inc = 1'b1;
         if (run_cnt >= RUN_W'(MAX_STALL)) begin
            err_nxt = 1'b1;
         end
         run_cnt_nxt = (run_cnt == {RUN_W{1'b1}}) ? run_cnt : run_cnt + RUN_W'(1);
      end else if (!imem_ready) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   assign state_o = state;

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bubble_inc),
      .count (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W = 4;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
   localparam logic [6:0] C_RUN  = 7'b1101011;
   localparam logic [6:0] C_BR   = 7'b1111111;
   localparam logic [6:0] C_STL  = 7'b0001111;
   localparam logic [6:0] C_MEM  = 7'b0000000;
   localparam logic [6:0] C_IMEM = 7'b0111011;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stall_req, branch_taken, imem_ready, dmem_req, dmem_ready;
   logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] bubble_cnt, flush_cnt;
   logic             err_stall;

   typedef struct {
      string            name;
      logic [6:0]       ctrl;
      logic [1:0]       st;
      logic [CNT_W-1:0] bub;
      logic [CNT_W-1:0] fl;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MAX_STALL(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_req    (stall_req),
      .branch_taken (branch_taken),
      .imem_ready   (imem_ready),
      .dmem_req     (dmem_req),
      .dmem_ready   (dmem_ready),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .ifid_flush   (ifid_flush),
      .idex_en      (idex_en),
      .idex_flush   (idex_flush),
      .exmem_en     (exmem_en),
      .memwb_en     (memwb_en),
      .state_o      (state_o),
      .bubble_cnt   (bubble_cnt),
      .flush_cnt    (flush_cnt),
      .err_stall    (err_stall)
   );

   // Monitor: compares DUT outputs mid-cycle against the oldest expectation
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [6:0] ctrl;
         e = exp_q.pop_front();
         ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
         checks++;
         if (ctrl !== e.ctrl) begin
            errors++;
            $display("FAIL %s ctrl: got %b expected %b", e.name, ctrl, e.ctrl);
         end
         checks++;
         if (state_o !== e.st) begin
            errors++;
            $display("FAIL %s state_o: got %0d expected %0d", e.name, state_o, e.st);
         end
         checks++;
         if (bubble_cnt !== e.bub) begin
            errors++;
            $display("FAIL %s bubble_cnt: got %0d expected %0d", e.name, bubble_cnt, e.bub);
         end
         checks++;
         if (flush_cnt !== e.fl) begin
            errors++;
            $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fl);
         end
         checks++;
         if (err_stall !== e.err) begin
            errors++;
            $display("FAIL %s err_stall: got %b expected %b", e.name, err_stall, e.err);
         end
      end
   end

   task automatic push(input string name, input logic [6:0] ctrl, input logic [1:0] st,
                       input int bub, input int fl, input logic err);
      exp_t e;
      e.name = name;
      e.ctrl = ctrl;
      e.st   = st;
      e.bub  = CNT_W'(bub);
      e.fl   = CNT_W'(fl);
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // One cycle: drive inputs just after the rising edge, queue expectation
   task automatic step(input string name, input logic s, input logic br, input logic im,
                       input logic dq, input logic dr, input logic [6:0] ctrl,
                       input logic [1:0] st, input int bub, input int fl, input logic err);
      @(posedge clk);
      #1;
      stall_req    = s;
      branch_taken = br;
      imem_ready   = im;
      dmem_req     = dq;
      dmem_ready   = dr;
      push(name, ctrl, st, bub, fl, err);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      stall_req    = 1'b0;
      branch_taken = 1'b0;
      imem_ready   = 1'b1;
      dmem_req     = 1'b0;
      dmem_ready   = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n        = 1'b0;
      stall_req    = 1'b0;
      branch_taken = 1'b0;
      imem_ready   = 1'b1;
      dmem_req     = 1'b0;
      dmem_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      push("reset_idle", C_RUN, 2'd0, 0, 0, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Reset asserted asynchronously in the middle of a stall run
      step("rms_c0", 1, 0, 1, 0, 0, C_STL, 2'd1 - 2'd1, 0, 0, 1'b0);
      step("rms_c1", 1, 0, 1, 0, 0, C_STL, 2'd1, 1, 0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      push("rms_async", C_RUN, 2'd0, 0, 0, 1'b0);
      @(posedge clk);
      #3;
      rst_n     = 1'b1;
      stall_req = 1'b0;

      // Single load-use bubble, then a fetch bubble
      apply_reset();
      step("lu_c0",   1, 0, 1, 0, 0, C_STL,  2'd0, 0, 0, 1'b0);
      step("lu_c1",   0, 0, 1, 0, 0, C_RUN,  2'd1, 1, 0, 1'b0);
      step("lu_c2",   0, 0, 1, 0, 0, C_RUN,  2'd0, 1, 0, 1'b0);
      step("imem_c0", 0, 0, 0, 0, 0, C_IMEM, 2'd0, 1, 0, 1'b0);
      step("imem_c1", 0, 0, 1, 0, 0, C_RUN,  2'd0, 1, 0, 1'b0);

      // Branch and stall together; stall ignored in the FLUSH cycle
      apply_reset();
      step("bs_c0", 1, 1, 1, 0, 0, C_BR,  2'd0, 0, 0, 1'b0);
      step("bs_c1", 1, 0, 1, 0, 0, C_RUN, 2'd3, 0, 1, 1'b0);
      step("bs_c2", 0, 0, 1, 0, 0, C_RUN, 2'd0, 0, 1, 1'b0);

      // Memory wait freezes everything, branch resolves on release
      apply_reset();
      step("mw_c0", 0, 0, 1, 1, 0, C_MEM, 2'd0, 0, 0, 1'b0);
      step("mw_c1", 1, 1, 1, 1, 0, C_MEM, 2'd2, 0, 0, 1'b0);
      step("mw_c2", 0, 0, 1, 1, 0, C_MEM, 2'd2, 0, 0, 1'b0);
      step("mw_c3", 0, 1, 1, 1, 1, C_BR,  2'd2, 0, 0, 1'b0);
      step("mw_c4", 0, 0, 1, 0, 0, C_RUN, 2'd3, 0, 1, 1'b0);
      step("mw_c5", 0, 0, 1, 0, 0, C_RUN, 2'd0, 0, 1, 1'b0);

      // Watchdog: 9 consecutive stalls trip it, and it stays set
      apply_reset();
      step("wd9_c0", 1, 0, 1, 0, 0, C_STL, 2'd0, 0, 0, 1'b0);
      for (int i = 1; i < 9; i++) begin
         step("wd9_run", 1, 0, 1, 0, 0, C_STL, 2'd1, i, 0, 1'b0);
      end
      step("wd9_rel0", 0, 0, 1, 0, 0, C_RUN, 2'd1, 9, 0, 1'b1);
      step("wd9_rel1", 0, 0, 1, 0, 0, C_RUN, 2'd0, 9, 0, 1'b1);
      step("wd9_rel2", 0, 0, 1, 0, 0, C_RUN, 2'd0, 9, 0, 1'b1);

      // Watchdog: exactly 8 consecutive stalls stay legal
      apply_reset();
      step("wd8_c0", 1, 0, 1, 0, 0, C_STL, 2'd0, 0, 0, 1'b0);
      for (int i = 1; i < 8; i++) begin
         step("wd8_run", 1, 0, 1, 0, 0, C_STL, 2'd1, i, 0, 1'b0);
      end
      step("wd8_rel0", 0, 0, 1, 0, 0, C_RUN, 2'd1, 8, 0, 1'b0);
      step("wd8_rel1", 0, 0, 1, 0, 0, C_RUN, 2'd0, 8, 0, 1'b0);

      // Saturation: 20 separate single-cycle stalls on a 4-bit counter
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         step("sat_stall", 1, 0, 1, 0, 0, C_STL, 2'd0, (i > 15) ? 15 : i, 0, 1'b0);
         step("sat_idle",  0, 0, 1, 0, 0, C_RUN, 2'd1, (i + 1 > 15) ? 15 : i + 1, 0, 1'b0);
      end
      step("sat_hold", 0, 0, 1, 0, 0, C_RUN, 2'd0, 15, 0, 1'b0);

      // Drain the scoreboard within a bounded number of cycles
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
         @(posedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
